// File: rtl/kb_ascii_stream_pkg.sv
// Shared scan-code constants, ASCII constants and decoder state encoding
// for the keyboard-to-UART ASCII stream.
package kb_ascii_stream_pkg;

  localparam logic [7:0] SC_BRK     = 8'hF0;
  localparam logic [7:0] SC_EXT     = 8'hE0;
  localparam logic [7:0] SC_LSHIFT  = 8'h12;
  localparam logic [7:0] SC_RSHIFT  = 8'h59;
  localparam logic [7:0] SC_CAPS    = 8'h58;
  localparam logic [7:0] SC_ENTER   = 8'h5A;
  localparam logic [7:0] SC_KPSLASH = 8'h4A;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_UNK   = 8'h2A;
  localparam logic [7:0] ASCII_SLASH = 8'h2F;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXT     = 3'd1,
    ST_BRK     = 3'd2,
    ST_EXT_BRK = 3'd3,
    ST_LF      = 3'd4
  } kb_state_e;

endpackage

// File: rtl/kb_ascii_stream_fifo.sv
// Circular character buffer; a push into a full buffer is only accepted
// when a pop frees a slot in the same cycle.
module kb_ascii_stream_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              rd_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              empty_o,
  output logic              full_o
);

  localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};

  logic [DATA_W-1:0] mem_q [(1 << ADDR_W)];
  logic [ADDR_W-1:0] wptr_q, rptr_q;
  logic [ADDR_W:0]   cnt_q;
  logic              wr_en_s, rd_en_s;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == DEPTH_C);
  assign rd_en_s = rd_i & ~empty_o;
  assign wr_en_s = wr_i & (~full_o | rd_en_s);
  assign rdata_o = mem_q[rptr_q];

  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_en_s) wptr_q <= wptr_q + ADDR_W'(1);
      if (rd_en_s) rptr_q <= rptr_q + ADDR_W'(1);
      case ({wr_en_s, rd_en_s})
        2'b10:   cnt_q <= cnt_q + (ADDR_W+1)'(1);
        2'b01:   cnt_q <= cnt_q - (ADDR_W+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/kb_ascii_stream.sv
// PS/2 scan-byte decoder with shift/caps tracking and ASCII translation,
// feeding a character FIFO that drains into a UART transmitter.
module kb_ascii_stream
  import kb_ascii_stream_pkg::*;
#(
  parameter int FIFO_W       = 4,
  parameter bit DROP_UNKNOWN = 1'b1,
  parameter bit REPEAT_EN    = 1'b1,
  parameter bit CRLF         = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  input  logic       tx_full,
  output logic       wr_uart,
  output logic [7:0] w_data,
  output logic       caps_led,
  output logic       ovf
);

  kb_state_e  state_q, state_d;
  logic       tick_q;
  logic [7:0] code_q, last_make_q, last_make_d;
  logic       shift_l_q, shift_l_d, shift_r_q, shift_r_d, caps_q, caps_d, ovf_q;
  logic       push_s, ovf_evt_s, lf_pend_s, empty_s, full_s, shift_s, xlat_vld_s;
  logic [7:0] push_data_s, letter_s, xlat_s;
  logic [15:0] sym_s;

  // Lower-case letter for a make code, 0 when the code is not a letter.
  function automatic logic [7:0] letter_of(input logic [7:0] code);
    case (code)
      8'h1C: letter_of = 8'h61;  8'h32: letter_of = 8'h62;  8'h21: letter_of = 8'h63;
      8'h23: letter_of = 8'h64;  8'h24: letter_of = 8'h65;  8'h2B: letter_of = 8'h66;
      8'h34: letter_of = 8'h67;  8'h33: letter_of = 8'h68;  8'h43: letter_of = 8'h69;
      8'h3B: letter_of = 8'h6A;  8'h42: letter_of = 8'h6B;  8'h4B: letter_of = 8'h6C;
      8'h3A: letter_of = 8'h6D;  8'h31: letter_of = 8'h6E;  8'h44: letter_of = 8'h6F;
      8'h4D: letter_of = 8'h70;  8'h15: letter_of = 8'h71;  8'h2D: letter_of = 8'h72;
      8'h1B: letter_of = 8'h73;  8'h2C: letter_of = 8'h74;  8'h3C: letter_of = 8'h75;
      8'h2A: letter_of = 8'h76;  8'h1D: letter_of = 8'h77;  8'h22: letter_of = 8'h78;
      8'h35: letter_of = 8'h79;  8'h1A: letter_of = 8'h7A;
      default: letter_of = 8'h00;
    endcase
  endfunction

  // {unshifted, shifted} US-layout pair for digits/symbols, 0 when unmapped.
  function automatic logic [15:0] symbol_of(input logic [7:0] code);
    case (code)
      8'h45: symbol_of = {8'h30, 8'h29};  8'h16: symbol_of = {8'h31, 8'h21};
      8'h1E: symbol_of = {8'h32, 8'h40};  8'h26: symbol_of = {8'h33, 8'h23};
      8'h25: symbol_of = {8'h34, 8'h24};  8'h2E: symbol_of = {8'h35, 8'h25};
      8'h36: symbol_of = {8'h36, 8'h5E};  8'h3D: symbol_of = {8'h37, 8'h26};
      8'h3E: symbol_of = {8'h38, 8'h2A};  8'h46: symbol_of = {8'h39, 8'h28};
      8'h0E: symbol_of = {8'h60, 8'h7E};  8'h4E: symbol_of = {8'h2D, 8'h5F};
      8'h55: symbol_of = {8'h3D, 8'h2B};  8'h5D: symbol_of = {8'h5C, 8'h7C};
      8'h54: symbol_of = {8'h5B, 8'h7B};  8'h5B: symbol_of = {8'h5D, 8'h7D};
      8'h4C: symbol_of = {8'h3B, 8'h3A};  8'h52: symbol_of = {8'h27, 8'h22};
      8'h41: symbol_of = {8'h2C, 8'h3C};  8'h49: symbol_of = {8'h2E, 8'h3E};
      8'h4A: symbol_of = {8'h2F, 8'h3F};  8'h29: symbol_of = {8'h20, 8'h20};
      8'h66: symbol_of = {8'h08, 8'h08};  8'h0D: symbol_of = {8'h09, 8'h09};
      default: symbol_of = 16'h0000;
    endcase
  endfunction

  assign shift_s  = shift_l_q | shift_r_q;
  assign letter_s = letter_of(code_q);
  assign sym_s    = symbol_of(code_q);

  // Case-correct translation of the registered scan byte.
  always_comb begin
    xlat_vld_s = 1'b1;
    if (letter_s != 8'h00) begin
      xlat_s = (shift_s ^ caps_q) ? (letter_s - 8'h20) : letter_s;
    end else if (sym_s != 16'h0000) begin
      xlat_s = shift_s ? sym_s[7:0] : sym_s[15:8];
    end else begin
      xlat_s     = ASCII_UNK;
      xlat_vld_s = ~DROP_UNKNOWN;
    end
  end

  // Input byte pipeline and modifier/overflow state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_q      <= 1'b0;
      code_q      <= 8'h00;
      shift_l_q   <= 1'b0;
      shift_r_q   <= 1'b0;
      caps_q      <= 1'b0;
      last_make_q <= 8'h00;
      ovf_q       <= 1'b0;
    end else begin
      tick_q      <= rx_done_tick;
      code_q      <= rx_data;
      shift_l_q   <= shift_l_d;
      shift_r_q   <= shift_r_d;
      caps_q      <= caps_d;
      last_make_q <= last_make_d;
      ovf_q       <= ovf_q | ovf_evt_s | (push_s & full_s & ~wr_uart);
    end
  end

  // Decoder state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  assign lf_pend_s = CRLF & push_s & (push_data_s == ASCII_CR);

  // Decoder next-state logic; only a registered tick advances the prefix states.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!tick_q)                 state_d = ST_IDLE;
        else if (code_q == SC_EXT)   state_d = ST_EXT;
        else if (code_q == SC_BRK)   state_d = ST_BRK;
        else if (lf_pend_s)          state_d = ST_LF;
        else                         state_d = ST_IDLE;
      end
      ST_EXT: begin
        if (!tick_q)                 state_d = ST_EXT;
        else if (code_q == SC_BRK)   state_d = ST_EXT_BRK;
        else if (lf_pend_s)          state_d = ST_LF;
        else                         state_d = ST_IDLE;
      end
      ST_BRK:     state_d = tick_q ? ST_IDLE : ST_BRK;
      ST_EXT_BRK: state_d = tick_q ? ST_IDLE : ST_EXT_BRK;
      ST_LF:      state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Decoder actions: modifier updates and FIFO pushes.
  always_comb begin
    push_s      = 1'b0;
    push_data_s = 8'h00;
    shift_l_d   = shift_l_q;
    shift_r_d   = shift_r_q;
    caps_d      = caps_q;
    last_make_d = last_make_q;
    ovf_evt_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tick_q && (code_q != SC_EXT) && (code_q != SC_BRK)) begin
          last_make_d = code_q;
          if (code_q == SC_LSHIFT)      shift_l_d = 1'b1;
          else if (code_q == SC_RSHIFT) shift_r_d = 1'b1;
          else if (code_q == SC_CAPS)   caps_d = (last_make_q != SC_CAPS) ? ~caps_q : caps_q;
          else if (!REPEAT_EN && (code_q == last_make_q)) push_s = 1'b0;
          else if (code_q == SC_ENTER) begin
            push_s      = 1'b1;
            push_data_s = ASCII_CR;
          end else begin
            push_s      = xlat_vld_s;
            push_data_s = xlat_s;
          end
        end else begin
          push_s = 1'b0;
        end
      end
      // Extended makes: only Enter and keypad slash produce output; fake shifts are ignored.
      ST_EXT: begin
        if (tick_q && (code_q == SC_ENTER)) begin
          push_s      = 1'b1;
          push_data_s = ASCII_CR;
        end else if (tick_q && (code_q == SC_KPSLASH)) begin
          push_s      = 1'b1;
          push_data_s = ASCII_SLASH;
        end else begin
          push_s = 1'b0;
        end
      end
      ST_BRK: begin
        if (tick_q) begin
          if (code_q == SC_LSHIFT)      shift_l_d = 1'b0;
          else if (code_q == SC_RSHIFT) shift_r_d = 1'b0;
          else                          shift_l_d = shift_l_q;
          if (code_q == last_make_q)    last_make_d = 8'h00;
          else                          last_make_d = last_make_q;
        end else begin
          last_make_d = last_make_q;
        end
      end
      ST_EXT_BRK: push_s = 1'b0;
      ST_LF: begin
        push_s      = 1'b1;
        push_data_s = ASCII_LF;
        ovf_evt_s   = tick_q;
      end
      default: push_s = 1'b0;
    endcase
  end

  kb_ascii_stream_fifo #(
    .DATA_W (8),
    .ADDR_W (FIFO_W)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .wr_i    (push_s),
    .wdata_i (push_data_s),
    .rd_i    (wr_uart),
    .rdata_o (w_data),
    .empty_o (empty_s),
    .full_o  (full_s)
  );

  assign wr_uart  = ~empty_s & ~tx_full;
  assign caps_led = caps_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_kb_ascii_stream.sv
// Directed bench: scan-byte sequences with hand-computed ASCII results,
// checked on a default instance and a REPEAT_EN=0 instance.
module tb_kb_ascii_stream;

  logic       clk = 1'b0;
  logic       reset, rx_done_tick, tx_full;
  logic [7:0] rx_data;
  logic       wr_uart0, caps0, ovf0, wr_uart1, caps1, ovf1;
  logic [7:0] wdata0, wdata1;
  int         vec_cnt = 0;
  int         miscmp_cnt = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] ltr [17] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                           8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15};

  always #5 clk = ~clk;

  kb_ascii_stream dut (
    .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data), .tx_full(tx_full),
    .wr_uart(wr_uart0), .w_data(wdata0), .caps_led(caps0), .ovf(ovf0)
  );

  kb_ascii_stream #(.FIFO_W(4), .DROP_UNKNOWN(1'b1), .REPEAT_EN(1'b0), .CRLF(1'b1)) dut_nr (
    .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data), .tx_full(tx_full),
    .wr_uart(wr_uart1), .w_data(wdata1), .caps_led(caps1), .ovf(ovf1)
  );

  // UART side: every cycle with wr_uart high pops one byte.
  always @(negedge clk) begin
    if (!reset && wr_uart0) q0.push_back(wdata0);
    if (!reset && wr_uart1) q1.push_back(wdata1);
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscmp_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic pop_chk(input string tag, input bit which, input logic [7:0] exp);
    logic [8:0] got;
    got = 9'h000;
    if (!which && q0.size() != 0) got = {1'b1, q0.pop_front()};
    if (which && q1.size() != 0)  got = {1'b1, q1.pop_front()};
    chk(tag, {7'h00, got}, {8'h01, exp});
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    rx_done_tick = 1'b1;
    @(posedge clk); #1;
    rx_done_tick = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic look(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1; rx_done_tick = 1'b0; rx_data = 8'h00; tx_full = 1'b0;
    #1;
    chk("rst_wr_uart", {15'h0, wr_uart0}, 16'h0000);
    chk("rst_caps", {15'h0, caps0}, 16'h0000);
    chk("rst_ovf", {15'h0, ovf0}, 16'h0000);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // 1: 'a' with latency check, then an unmapped code
    @(posedge clk); #1;
    rx_data = 8'h1C; rx_done_tick = 1'b1;
    @(posedge clk); #1;
    rx_done_tick = 1'b0;
    #1 chk("lat_n1_wr_uart", {15'h0, wr_uart0}, 16'h0000);
    @(posedge clk); #2;
    chk("lat_n2_wr_uart", {15'h0, wr_uart0}, 16'h0001);
    chk("lat_n2_w_data", {8'h00, wdata0}, 16'h0061);
    send(8'hF0); send(8'h1C); send(8'h01);
    look(4);
    pop_chk("t1_a", 1'b0, 8'h61);
    chk("t1_count", 16'(q0.size()), 16'h0000);
    chk("t1_ovf", {15'h0, ovf0}, 16'h0000);

    // 2: shift, caps, auto-repeated caps
    send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
    send(8'h58); send(8'hF0); send(8'h58); send(8'h1C);
    send(8'h12); send(8'h1C); send(8'h16); send(8'hF0); send(8'h12);
    look(4);
    chk("t2_caps_on", {15'h0, caps0}, 16'h0001);
    pop_chk("t2_shift_A", 1'b0, 8'h41);
    pop_chk("t2_caps_A", 1'b0, 8'h41);
    pop_chk("t2_caps_shift_a", 1'b0, 8'h61);
    pop_chk("t2_shift_1", 1'b0, 8'h21);
    chk("t2_count", 16'(q0.size()), 16'h0000);
    send(8'h58); send(8'h58);
    look(2);
    chk("t2_caps_repeat", {15'h0, caps0}, 16'h0000);
    send(8'hF0); send(8'h58); send(8'h58); send(8'hF0); send(8'h58);
    look(2);
    chk("t2_caps_again", {15'h0, caps0}, 16'h0001);

    // 3: Enter forms, fake shifts, keypad slash, unknown extended
    send(8'h5A); send(8'hE0); send(8'h5A);
    send(8'h12); send(8'hE0); send(8'hF0); send(8'h12); send(8'h1C); send(8'hF0); send(8'h12);
    send(8'hE0); send(8'h12); send(8'h1C);
    send(8'hE0); send(8'h4A); send(8'hE0); send(8'h75);
    look(4);
    pop_chk("t3_cr", 1'b0, 8'h0D);
    pop_chk("t3_lf", 1'b0, 8'h0A);
    pop_chk("t3_ext_cr", 1'b0, 8'h0D);
    pop_chk("t3_ext_lf", 1'b0, 8'h0A);
    pop_chk("t3_fake_brk", 1'b0, 8'h61);
    pop_chk("t3_fake_make", 1'b0, 8'h41);
    pop_chk("t3_kpslash", 1'b0, 8'h2F);
    chk("t3_count", 16'(q0.size()), 16'h0000);

    // 4: typematic '1' with caps on
    q1.delete();
    send(8'h16); send(8'h16); send(8'h16);
    send(8'hF0); send(8'h16); send(8'h16);
    look(4);
    for (int i = 0; i < 4; i++) pop_chk("t4_rep_on", 1'b0, 8'h31);
    chk("t4_rep_on_count", 16'(q0.size()), 16'h0000);
    pop_chk("t4_rep_off_1", 1'b1, 8'h31);
    pop_chk("t4_rep_off_2", 1'b1, 8'h31);
    chk("t4_rep_off_count", 16'(q1.size()), 16'h0000);

    // 5: 17 letters into a 16-deep FIFO under backpressure
    chk("t5_ovf_before", {15'h0, ovf0}, 16'h0000);
    @(posedge clk); #1 tx_full = 1'b1;
    for (int i = 0; i < 17; i++) send(ltr[i]);
    look(2);
    chk("t5_ovf", {15'h0, ovf0}, 16'h0001);
    chk("t5_held_wr_uart", {15'h0, wr_uart0}, 16'h0000);
    chk("t5_held_w_data", {8'h00, wdata0}, 16'h0041);
    chk("t5_held_count", 16'(q0.size()), 16'h0000);
    @(posedge clk); #1 tx_full = 1'b0;
    look(20);
    chk("t5_drain_count", 16'(q0.size()), 16'h0010);
    for (int i = 0; i < 16; i++) pop_chk("t5_order", 1'b0, 8'(8'h41 + i));
    chk("t5_idle_wr_uart", {15'h0, wr_uart0}, 16'h0000);
    q1.delete();

    // 6: reset mid-prefix with a queued char, then reset with LF pending
    @(posedge clk); #1 tx_full = 1'b1;
    send(8'h1C); send(8'hE0);
    @(posedge clk); #1;
    reset = 1'b1; tx_full = 1'b0;
    #1;
    chk("t6_rst_wr_uart", {15'h0, wr_uart0}, 16'h0000);
    chk("t6_rst_caps", {15'h0, caps0}, 16'h0000);
    chk("t6_rst_ovf", {15'h0, ovf0}, 16'h0000);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    send(8'h1C);
    look(4);
    pop_chk("t6_after_prefix", 1'b0, 8'h61);
    chk("t6_count1", 16'(q0.size()), 16'h0000);
    @(posedge clk); #1;
    rx_data = 8'h5A; rx_done_tick = 1'b1;
    @(posedge clk); #1 rx_done_tick = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    #1 chk("t6_lf_rst_wr_uart", {15'h0, wr_uart0}, 16'h0000);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    look(4);
    chk("t6_no_lf", 16'(q0.size()), 16'h0000);
    send(8'h1C);
    look(4);
    pop_chk("t6_after_lf", 1'b0, 8'h61);
    chk("t6_count2", 16'(q0.size()), 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule
